// File: rtl/probe_queue_arbiter.sv
// probe_queue_arbiter
// Round-robin arbiter that collects probe requests from NREQ L2 slices into
// a single holding register feeding the shared probe queue, while keeping the
// number of downstream in-flight probes at or below MAX_OUT.
// Optional starvation watchdog: define PROBE_ARB_STARVE_CHK_EN to build it;
// otherwise starve_err is tied low.

module probe_queue_arbiter #(
    parameter int NREQ         = 4,
    parameter int ADDR_W       = 36,
    parameter int MAX_OUT      = 8,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [NREQ-1:0]                          req_valid,
    input  logic [NREQ*ADDR_W-1:0]                   req_addr,
    output logic [NREQ-1:0]                          req_ready,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [ADDR_W-1:0]                        out_addr,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] out_src,
    input  logic                                     done,
    output logic [3:0]                               outstanding,
    output logic                                     starve_err
);

    localparam int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Elaboration-time parameter range guards.
    if (MAX_OUT < 1 || MAX_OUT > 15) begin : g_bad_max_out
        $error("probe_queue_arbiter: MAX_OUT must be in 1..15");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
        $error("probe_queue_arbiter: STARVE_LIMIT must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [SRC_W-1:0]   rr_ptr_r;
    logic [ADDR_W-1:0]  hold_addr_r;
    logic [SRC_W-1:0]   hold_src_r;
    logic [3:0]         outstanding_r;

    logic               found_s;
    logic [SRC_W-1:0]   grant_idx_s;
    logic               grant_en_s;
    logic               grant_fire_s;
    logic               enq_s;
    logic               dec_s;
    logic [4:0]         out_next_s;

    // (base + offset) mod NREQ without relying on NREQ being a power of two.
    function automatic logic [SRC_W-1:0] wrap_idx(input logic [SRC_W-1:0] base, input int offset);
        int sum_v;
        sum_v = int'(base) + offset;
        if (sum_v >= NREQ) begin
            sum_v = sum_v - NREQ;
        end else begin
            sum_v = sum_v;
        end
        return SRC_W'(sum_v);
    endfunction

    // Downstream accounting: enqueue on handshake, done only counts when something is in flight.
    always_comb begin
        enq_s      = (state_r == ST_HOLD) && out_ready && (outstanding_r < 4'(MAX_OUT));
        dec_s      = done && (outstanding_r != 4'd0);
        out_next_s = {1'b0, outstanding_r} + {4'd0, enq_s} - {4'd0, dec_s};
    end

    // Round-robin search starting at rr_ptr, ascending with wrap.
    always_comb begin
        found_s     = 1'b0;
        grant_idx_s = {SRC_W{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            if (!found_s && req_valid[wrap_idx(rr_ptr_r, k)]) begin
                found_s     = 1'b1;
                grant_idx_s = wrap_idx(rr_ptr_r, k);
            end else begin
                found_s     = found_s;
            end
        end
    end

    // A grant needs a free holding register this cycle and room downstream after this cycle's updates.
    always_comb begin
        grant_en_s   = ((state_r != ST_HOLD) || enq_s) && (out_next_s < 5'(MAX_OUT));
        grant_fire_s = found_s && grant_en_s;
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state: HOLD while the register is full, STALL when empty with the window exhausted.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (grant_fire_s) begin
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (grant_fire_s || !enq_s) begin
                    state_next_s = ST_HOLD;
                end else if (out_next_s == 5'(MAX_OUT)) begin
                    state_next_s = ST_STALL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_STALL: begin
                if (grant_fire_s) begin
                    state_next_s = ST_HOLD;
                end else if (out_next_s == 5'(MAX_OUT)) begin
                    state_next_s = ST_STALL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: one-hot accept to the winner (held low during reset), valid while holding.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = reset && grant_fire_s && (grant_idx_s == SRC_W'(i));
        end
        case (state_r)
            ST_HOLD:  out_valid = 1'b1;
            ST_IDLE:  out_valid = 1'b0;
            ST_STALL: out_valid = 1'b0;
            default:  out_valid = 1'b0;
        endcase
    end

    // Holding register, round-robin pointer and in-flight counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_r      <= {SRC_W{1'b0}};
            hold_addr_r   <= {ADDR_W{1'b0}};
            hold_src_r    <= {SRC_W{1'b0}};
            outstanding_r <= 4'd0;
        end else begin
            outstanding_r <= out_next_s[3:0];
            if (grant_fire_s) begin
                rr_ptr_r    <= wrap_idx(grant_idx_s, 1);
                hold_addr_r <= req_addr[grant_idx_s*ADDR_W +: ADDR_W];
                hold_src_r  <= grant_idx_s;
            end else begin
                rr_ptr_r    <= rr_ptr_r;
                hold_addr_r <= hold_addr_r;
                hold_src_r  <= hold_src_r;
            end
        end
    end

    assign out_addr    = hold_addr_r;
    assign out_src     = hold_src_r;
    assign outstanding = outstanding_r;

`ifdef PROBE_ARB_STARVE_CHK_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [NREQ-1:0][CNT_W-1:0] wait_cnt_r;
    logic [NREQ-1:0][CNT_W-1:0] wait_next_s;
    logic                       starve_hit_s;
    logic                       starve_err_r;

    // Per-slice wait counters: count refused cycles, clear on grant or valid drop, saturate at the limit.
    always_comb begin
        wait_next_s  = {NREQ{{CNT_W{1'b0}}}};
        starve_hit_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && !req_ready[i]) begin
                if (wait_cnt_r[i] == LIMIT_C) begin
                    wait_next_s[i] = wait_cnt_r[i];
                end else begin
                    wait_next_s[i] = wait_cnt_r[i] + CNT_W'(1);
                end
            end else begin
                wait_next_s[i] = {CNT_W{1'b0}};
            end
            if (wait_next_s[i] == LIMIT_C) begin
                starve_hit_s = 1'b1;
            end else begin
                starve_hit_s = starve_hit_s;
            end
        end
    end

    // Wait counters and sticky starvation flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt_r   <= {NREQ{{CNT_W{1'b0}}}};
            starve_err_r <= 1'b0;
        end else begin
            wait_cnt_r   <= wait_next_s;
            starve_err_r <= starve_err_r | starve_hit_s;
        end
    end

    assign starve_err = starve_err_r;
`else
    assign starve_err = 1'b0;
`endif

endmodule
